otter_dcache_ctrl: RTL
======================

Name: otter_dcache_ctrl

Overview:
Direct-mapped, write-back, write-allocate data cache controller for the pipelined OTTER core's MEM stage. It consumes the load/store controls the control unit produces, after they travel through the EX/MEM register, together with the ALU-computed address and store data. It serves hits with no stall cycles. On a miss it stalls the pipeline while it writes back a dirty victim line and/or fills the line from main memory over a request/acknowledge line interface.

Parameters:
NUM_LINES, 16, number of cache lines (power of 2)
WORDS_PER_LINE, 4, 32-bit words per line (power of 2)
ADDR_W, 32, byte-address width

Ports:
DC_CLK  in  1  clock
DC_RESET  in  1  synchronous active-high reset
DC_READ  in  1  load in MEM stage (control unit's memory-read, registered)
DC_WRITE  in  1  store in MEM stage (control unit's memory-write, registered)
DC_ADDR  in  ADDR_W  byte address
DC_WDATA  in  32  store data, already lane-aligned
DC_BE  in  4  byte enables for store
DC_RDATA  out  32  load word (full aligned word)
DC_STALL  out  1  freeze PC/IF/ID/EX/MEM registers this cycle
MEM_REQ  out  1  line request to main memory
MEM_WE  out  1  1 = write-back of line, 0 = line fill
MEM_ADDR  out  ADDR_W  line-aligned byte address
MEM_WDATA  out  32*WORDS_PER_LINE  victim line data
MEM_RDATA  in  32*WORDS_PER_LINE  fill line data
MEM_ACK  in  1  single-cycle completion pulse

Behaviour:
- Clock and reset: one clock, DC_CLK. DC_RESET is synchronous and active-high.
- Address split: offset = log2(WORDS_PER_LINE*4) bits (4), index = log2(NUM_LINES) bits (4), tag = remaining upper bits (24). DC_ADDR[1:0] is ignored.
- Access: access = DC_READ | DC_WRITE. If both are asserted, the access is treated as a write.
- Hit: hit = access & valid[idx] & (tag[idx] == addr tag).
- Reset: on the next edge with DC_RESET=1, all valid and dirty bits clear, state = IDLE, MEM_REQ=0, MEM_WE=0. Data and tag arrays are not reset.
- States: IDLE, WRITEBACK, ALLOCATE.
- IDLE
  - DC_STALL = access & ~hit (combinational, same cycle).
  - Read hit: DC_RDATA = selected word combinationally, zero stall.
  - Write hit: byte lanes per DC_BE update at the edge; dirty[idx] set.
  - Miss with victim valid & dirty: go to WRITEBACK.
  - Any other miss: go to ALLOCATE.
  - No access: DC_RDATA = 0.
- WRITEBACK
  - DC_STALL=1, MEM_REQ=1, MEM_WE=1.
  - MEM_ADDR = {victim tag, idx, offset 0}; MEM_WDATA = victim line.
  - MEM_REQ, MEM_WE, MEM_ADDR and MEM_WDATA hold stable until MEM_ACK.
  - On MEM_ACK: dirty[idx] clears; go to ALLOCATE.
- ALLOCATE
  - DC_STALL=1, MEM_REQ=1, MEM_WE=0.
  - MEM_ADDR = {req tag, idx, 0}; held stable until MEM_ACK.
  - On MEM_ACK: line = MEM_RDATA, tag written, valid=1, dirty=0; go to IDLE.
- Retry: back in IDLE, the still-held access re-evaluates as a hit. A store then merges and sets dirty.
- Minimum miss penalty:
  - Clean miss with ACK in the first request cycle: 2 stall cycles.
  - Dirty miss: 3 stall cycles.
- Outputs are registered-state decodes. In IDLE, MEM_REQ=0 and MEM_ADDR/MEM_WDATA are don't-care (drive 0).
- MEM_ACK while MEM_REQ=0 is ignored.
- The pipeline holds DC_ADDR/DC_READ/DC_WRITE stable while DC_STALL=1. If the access drops mid-miss, the fill still completes and the FSM returns to IDLE.
- Reset mid-WRITEBACK/ALLOCATE: abort to IDLE with MEM_REQ=0 next cycle. Memory drops the abandoned transaction.
- Same-index conflict: evicting line A for line B writes back A, then refills. Different tag, same index always misses.

Decomposition:
- Shared package otter_dcache_pkg:
  - dcache_state_t enum {IDLE, WRITEBACK, ALLOCATE}
  - localparam derivations OFFSET_W, INDEX_W, TAG_W, LINE_W
  - functions get_tag/get_index/get_word
- One sub-module: dcache_line_array.
  - Tag/valid/dirty/data storage with async read, per-byte write of one word, whole-line write, and valid/dirty clear on reset.
  - The controller FSM stays in otter_dcache_ctrl.

Test Plan:
- Reset, then DC_READ at 0x0000_1004: DC_STALL=1 for 2 cycles; MEM_REQ=1, MEM_WE=0, MEM_ADDR=0x0000_1000. MEM_ACK returns line {D,C,B,A} (word0=A). Third cycle DC_STALL=0 and DC_RDATA=B.
- Read again at 0x0000_1008 after the fill: DC_STALL=0 same cycle, DC_RDATA=C, MEM_REQ stays 0.
- Store 0xDEADBEEF, DC_BE=4'b0011, to 0x0000_1000 (hit, word A=0x11223344): the following read returns 0x1122BEEF; dirty set, no MEM_REQ.
- Load 0x0000_2000 (same index 0, new tag) with dirty line:
  - WRITEBACK first: MEM_WE=1, MEM_ADDR=0x0000_1000, MEM_WDATA word0=0x1122BEEF.
  - Then ALLOCATE to 0x0000_2000.
  - 3 stall cycles when ACK is immediate.
- Delay MEM_ACK 5 cycles in ALLOCATE: DC_STALL and MEM_REQ stay 1 with MEM_ADDR constant; a stray MEM_ACK in IDLE causes no state change.
- Assert DC_RESET during ALLOCATE: next cycle state=IDLE, MEM_REQ=0. A read of the previously valid address then misses (valid cleared).

Source files
------------

// File: rtl/otter_dcache_pkg.sv
// Shared types, default geometry and address helpers for the OTTER data cache.
package otter_dcache_pkg;

    localparam int NUM_LINES      = 16;
    localparam int WORDS_PER_LINE = 4;
    localparam int ADDR_W         = 32;

    localparam int OFFSET_W = $clog2(WORDS_PER_LINE * 4);
    localparam int INDEX_W  = $clog2(NUM_LINES);
    localparam int TAG_W    = ADDR_W - OFFSET_W - INDEX_W;
    localparam int LINE_W   = 32 * WORDS_PER_LINE;
    localparam int WSEL_W   = $clog2(WORDS_PER_LINE);

    typedef enum logic [1:0] {
        IDLE,
        WRITEBACK,
        ALLOCATE
    } dcache_state_t;

    function automatic logic [TAG_W-1:0] get_tag(input logic [ADDR_W-1:0] addr);
        return addr[ADDR_W-1 -: TAG_W];
    endfunction

    function automatic logic [INDEX_W-1:0] get_index(input logic [ADDR_W-1:0] addr);
        return addr[OFFSET_W +: INDEX_W];
    endfunction

    function automatic logic [WSEL_W-1:0] get_word(input logic [ADDR_W-1:0] addr);
        return addr[2 +: WSEL_W];
    endfunction

endpackage

// File: rtl/dcache_line_array.sv
// Tag/valid/dirty/data storage for the direct-mapped cache: asynchronous read of
// the indexed line, byte-lane store into one word, or whole-line fill.
module dcache_line_array
    import otter_dcache_pkg::*;
#(
    parameter int L_NUM_LINES = NUM_LINES,
    parameter int L_INDEX_W   = INDEX_W,
    parameter int L_TAG_W     = TAG_W,
    parameter int L_LINE_W    = LINE_W,
    parameter int L_WSEL_W    = WSEL_W
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    input  logic [L_INDEX_W-1:0] i_idx,
    output logic                 o_valid,
    output logic                 o_dirty,
    output logic [L_TAG_W-1:0]   o_tag,
    output logic [L_LINE_W-1:0]  o_line,
    input  logic                 i_word_we,
    input  logic [L_WSEL_W-1:0]  i_word_sel,
    input  logic [3:0]           i_be,
    input  logic [31:0]          i_wdata,
    input  logic                 i_line_we,
    input  logic [L_LINE_W-1:0]  i_line_data,
    input  logic [L_TAG_W-1:0]   i_tag,
    input  logic                 i_clr_dirty
);

    logic [L_NUM_LINES-1:0] r_valid;
    logic [L_NUM_LINES-1:0] r_dirty;
    logic [L_TAG_W-1:0]     r_tag  [L_NUM_LINES];
    logic [L_LINE_W-1:0]    r_data [L_NUM_LINES];

    assign o_valid = r_valid[i_idx];
    assign o_dirty = r_dirty[i_idx];
    assign o_tag   = r_tag[i_idx];
    assign o_line  = r_data[i_idx];

    // Status bits: cleared by reset, set by fill (valid) or store (dirty).
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_valid <= '0;
            r_dirty <= '0;
        end else begin
            if (i_clr_dirty) r_dirty[i_idx] <= 1'b0;
            if (i_line_we) begin
                r_valid[i_idx] <= 1'b1;
                r_dirty[i_idx] <= 1'b0;
            end
            if (i_word_we) r_dirty[i_idx] <= 1'b1;
        end
    end

    // Tag and data storage: fill writes the whole line, store merges byte lanes.
    // NOTE: storage arrays carry no reset; valid bits gate every use of them.
    always_ff @(posedge i_clk) begin
        if (i_line_we) begin
            r_data[i_idx] <= i_line_data;
            r_tag[i_idx]  <= i_tag;
        end
        if (i_word_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) r_data[i_idx][int'(i_word_sel) * 32 + b * 8 +: 8] <= i_wdata[b * 8 +: 8];
            end
        end
    end

endmodule

// File: rtl/otter_dcache_ctrl.sv
// Direct-mapped write-back / write-allocate data cache controller for the OTTER
// MEM stage. Hits complete with no stall; misses write back a dirty victim and
// fill the line over a request/acknowledge memory interface.
module otter_dcache_ctrl
    import otter_dcache_pkg::*;
#(
    parameter int NUM_LINES      = otter_dcache_pkg::NUM_LINES,
    parameter int WORDS_PER_LINE = otter_dcache_pkg::WORDS_PER_LINE,
    parameter int ADDR_W         = otter_dcache_pkg::ADDR_W
) (
    input  logic                          DC_CLK,
    input  logic                          DC_RESET,
    input  logic                          DC_READ,
    input  logic                          DC_WRITE,
    input  logic [ADDR_W-1:0]             DC_ADDR,
    input  logic [31:0]                   DC_WDATA,
    input  logic [3:0]                    DC_BE,
    output logic [31:0]                   DC_RDATA,
    output logic                          DC_STALL,
    output logic                          MEM_REQ,
    output logic                          MEM_WE,
    output logic [ADDR_W-1:0]             MEM_ADDR,
    output logic [32*WORDS_PER_LINE-1:0]  MEM_WDATA,
    input  logic [32*WORDS_PER_LINE-1:0]  MEM_RDATA,
    input  logic                          MEM_ACK
);

    localparam int L_OFFSET_W = $clog2(WORDS_PER_LINE * 4);
    localparam int L_INDEX_W  = $clog2(NUM_LINES);
    localparam int L_TAG_W    = ADDR_W - L_OFFSET_W - L_INDEX_W;
    localparam int L_LINE_W   = 32 * WORDS_PER_LINE;
    localparam int L_WSEL_W   = $clog2(WORDS_PER_LINE);

    dcache_state_t r_state;
    dcache_state_t w_next;

    logic [L_TAG_W-1:0]   w_tag;
    logic [L_INDEX_W-1:0] w_idx;
    logic [L_WSEL_W-1:0]  w_wsel;
    logic                 w_access;
    logic                 w_hit;
    logic                 w_valid;
    logic                 w_dirty;
    logic [L_TAG_W-1:0]   w_vtag;
    logic [L_LINE_W-1:0]  w_line;
    logic                 w_word_we;
    logic                 w_line_we;
    logic                 w_clr_dirty;
    logic                 w_unused_addr;

    assign w_tag         = DC_ADDR[ADDR_W-1 -: L_TAG_W];
    assign w_idx         = DC_ADDR[L_OFFSET_W +: L_INDEX_W];
    assign w_wsel        = DC_ADDR[2 +: L_WSEL_W];
    assign w_unused_addr = ^DC_ADDR[1:0];
    assign w_access      = DC_READ | DC_WRITE;
    assign w_hit         = w_access & w_valid & (w_vtag == w_tag);

    dcache_line_array #(
        .L_NUM_LINES (NUM_LINES),
        .L_INDEX_W   (L_INDEX_W),
        .L_TAG_W     (L_TAG_W),
        .L_LINE_W    (L_LINE_W),
        .L_WSEL_W    (L_WSEL_W)
    ) u_array (
        .i_clk       (DC_CLK),
        .i_reset     (DC_RESET),
        .i_idx       (w_idx),
        .o_valid     (w_valid),
        .o_dirty     (w_dirty),
        .o_tag       (w_vtag),
        .o_line      (w_line),
        .i_word_we   (w_word_we),
        .i_word_sel  (w_wsel),
        .i_be        (DC_BE),
        .i_wdata     (DC_WDATA),
        .i_line_we   (w_line_we),
        .i_line_data (MEM_RDATA),
        .i_tag       (w_tag),
        .i_clr_dirty (w_clr_dirty)
    );

    // State register; reset abandons any in-flight memory transaction.
    always_ff @(posedge DC_CLK) begin
        if (DC_RESET) r_state <= IDLE;
        else          r_state <= w_next;
    end

    // Next-state and output decode of the miss-handling FSM.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        w_next      = r_state;
        DC_STALL    = 1'b0;
        DC_RDATA    = '0;
        MEM_REQ     = 1'b0;
        MEM_WE      = 1'b0;
        MEM_ADDR    = '0;
        MEM_WDATA   = '0;
        w_word_we   = 1'b0;
        w_line_we   = 1'b0;
        w_clr_dirty = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_hit) begin
                    DC_RDATA  = w_line[int'(w_wsel) * 32 +: 32];
                    w_word_we = DC_WRITE;
                end else if (w_access) begin
                    DC_STALL = 1'b1;
                    w_next   = (w_valid && w_dirty) ? WRITEBACK : ALLOCATE;
                end
            end
            WRITEBACK: begin
                DC_STALL  = 1'b1;
                MEM_REQ   = 1'b1;
                MEM_WE    = 1'b1;
                MEM_ADDR  = {w_vtag, w_idx, {L_OFFSET_W{1'b0}}};
                MEM_WDATA = w_line;
                if (MEM_ACK) begin
                    w_clr_dirty = 1'b1;
                    w_next      = ALLOCATE;
                end
            end
            ALLOCATE: begin
                DC_STALL = 1'b1;
                MEM_REQ  = 1'b1;
                MEM_ADDR = {w_tag, w_idx, {L_OFFSET_W{1'b0}}};
                if (MEM_ACK) begin
                    w_line_we = 1'b1;
                    w_next    = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

endmodule
